timer_counter: RTL
==================

Name: timer_counter

Overview:
- Memory-mapped timer/counter peripheral sitting directly downstream of the system bridge; the bridge decodes the CPU address, raises this block's write enable and muxes this block's read data back to the CPU.
- Two instances are used, at bases 0x0000_7F00 and 0x0000_7F10.
- Each instance holds three registers (CTRL, PRESET, COUNT), counts down from PRESET, and raises an interrupt request to the CPU when the count reaches zero.
- Supports one-shot mode and auto-reload mode.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- addr  input  2  word select, driven from CPU address bits [3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
- we  input  1  write enable from bridge (already qualified by address decode).
- wdata  input  32  CPU store data.
- rdata  output  32  combinational read data for the selected register.
- irq  output  1  interrupt request to CPU.

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Registers:
  - CTRL[3:0]: bit0 EN, bits[2:1] MODE, bit3 IM (interrupt mask, 1=enabled); CTRL bits [31:4] read 0.
  - PRESET[31:0]: reload value.
  - COUNT[31:0]: read-only.
- Reset (async, reset_n=0): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. Outputs irq=0 and rdata=0 for every addr, immediately, without waiting for a clock edge.
- Reads:
  - rdata is combinational, no wait state.
  - addr0 -> {28'b0, CTRL}; addr1 -> PRESET; addr2 -> COUNT; addr3 -> 0.
- Writes (we=1, taken at the rising edge):
  - addr0: CTRL <= wdata[3:0] and irq_flag <= 0.
  - addr1: PRESET <= wdata.
  - addr2 and addr3: ignored.
- FSM state transitions read the registered CTRL value, so a write becomes visible to the FSM one cycle later.
- FSM states:
  - IDLE: if EN=1 -> LOAD; else stay. COUNT holds its value.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT: if EN=0 -> IDLE with COUNT frozen. Else if COUNT>1, COUNT <= COUNT-1. Else (COUNT is 1 or 0) COUNT <= 0, irq_flag <= 1, -> INT.
  - INT, MODE=01 (auto-reload): irq_flag <= 0; -> IDLE. EN stays 1, so the path IDLE->LOAD->CNT reloads the counter.
  - INT, MODE=00/10/11 (one-shot): CTRL.EN <= 0; -> IDLE. irq_flag is held until the CPU writes CTRL.
- irq = irq_flag & CTRL.IM, combinational from registers.
- Latency:
  - With PRESET=N>=1 and CTRL written with EN=1 at edge E0: LOAD at E1, COUNT=N at E2, COUNT reaches 0 and irq asserts at E(N+2).
  - With PRESET=0, irq asserts at E3.
  - Auto-reload period is N+3 cycles, and irq is high for exactly 1 cycle per period.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle as the INT-state EN clear: the CPU write wins.
  - A PRESET write during CNT: does not affect the current count; it takes effect on the next LOAD.
  - An EN=0 write during LOAD: COUNT is still loaded, then the FSM goes CNT -> IDLE.
- COUNT arithmetic is 32-bit unsigned, never wraps below 0, and never decrements outside CNT.

Test Plan:
- Reset / register access: reset_n=0 mid-count -> irq=0 and all reads 0 asynchronously. After release, write PRESET=0x1234 -> reads 0x1234 at addr1; write addr2=0xFF -> COUNT still reads 0.
- One-shot: PRESET=5, CTRL=0x9 at E0.
  - COUNT reads 5,4,3,2,1 on E2..E6.
  - COUNT=0 and irq=1 from E7; CTRL reads 0x8 after E8; irq stays 1.
  - Writing CTRL=0x8 drops irq next cycle.
- Auto-reload: PRESET=3, CTRL=0xB -> irq is a 1-cycle pulse every 6 cycles, first after E5; COUNT sequence 3,2,1,0 repeats.
- Masked: PRESET=2, CTRL=0x1 -> COUNT reaches 0 at E4, irq stays 0 throughout; CTRL reads 0x0 afterwards.
- Disable / re-enable: mid-count with COUNT=3, write CTRL=0x8 -> COUNT frozen at 2 (one decrement in flight) and state IDLE. Rewrite CTRL=0x9 -> COUNT reloads PRESET.
- Edge cases: PRESET=0 with enable -> irq after E3. CTRL write coinciding with the one-shot EN clear -> written EN value retained.

Source files
------------

// File: rtl/timer_counter.sv
// timer_counter
//    Memory-mapped down-counting timer with one-shot and auto-reload modes.
//    Three word registers: CTRL (addr 0), PRESET (addr 1), COUNT (addr 2, read-only).
//
// Ports
//    clk      system clock, rising-edge
//    reset_n  asynchronous active-low reset
//    addr     word select (CPU address bits [3:2])
//    we       write strobe, already qualified by the bridge
//    wdata    CPU store data
//    rdata    combinational read data for the selected word
//    irq      interrupt request (irq_flag gated by CTRL.IM)
//
// CTRL layout: [0] EN, [2:1] MODE (01 = auto-reload, others one-shot), [3] IM
//
// state | meaning
// IDLE  | waiting for EN, COUNT holds
// LOAD  | copy PRESET into COUNT
// CNT   | decrement until COUNT reaches 0
// INT   | terminal count hit; reload path or one-shot EN clear

module timer_counter (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_AUTO = 2'b01;

   state_t      state_q;
   logic [3:0]  ctrl_q;
   logic [31:0] preset_q;
   logic [31:0] count_q;
   logic        irq_flag_q;

   logic        en;
   logic [1:0]  mode;
   logic        im;

   assign en   = ctrl_q[0];
   assign mode = ctrl_q[2:1];
   assign im   = ctrl_q[3];

   // The CPU write is applied after the FSM update so that a CTRL write
   // landing on the one-shot EN clear (or on the irq set) takes priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ctrl_q     <= 4'h0;
         preset_q   <= 32'h0;
         count_q    <= 32'h0;
         irq_flag_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (en) state_q <= LOAD;
            end
            LOAD: begin
               count_q <= preset_q;
               state_q <= CNT;
            end
            CNT: begin
               if (!en) begin
                  state_q <= IDLE;
               end else if (count_q > 32'd1) begin
                  count_q <= count_q - 32'd1;
               end else begin
                  count_q    <= 32'h0;
                  irq_flag_q <= 1'b1;
                  state_q    <= INT;
               end
            end
            INT: begin
               if (mode == MODE_AUTO) irq_flag_q <= 1'b0;
               else                   ctrl_q[0]  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         if (we) begin
            case (addr)
               2'd0: begin
                  ctrl_q     <= wdata[3:0];
                  irq_flag_q <= 1'b0;
               end
               2'd1:    preset_q <= wdata;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rdata = 32'h0;
      case (addr)
         2'd0:    rdata = {28'h0, ctrl_q};
         2'd1:    rdata = preset_q;
         2'd2:    rdata = count_q;
         default: rdata = 32'h0;
      endcase
   end

   assign irq = irq_flag_q & im;

endmodule
